// File: rtl/ps2_pkg.sv
`default_nettype none
// ps2_pkg -- PS/2 framing constants, receiver FSM encoding and parity helper.
// Rev 1.0
package ps2_pkg;

  localparam int PS2_FRAME_BITS   = 11;
  localparam int PS2_PAYLOAD_BITS = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    STOP = 2'd2
  } ps2_state_t;

  // Odd-parity bit for a byte: set when the byte has an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ps2_line_filter -- 2-flop synchronizer plus saturating glitch filter for one PS/2 line.
// Rev 1.0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // The level flips one cycle after FILTER_LEN consecutive opposite samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (cnt == CW'(FILTER_LEN)) begin
        level <= ~level;
        cnt   <= '0;
      end else if (sync[1] != level) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ps2_rx -- PS/2 device-to-host receiver: filters the line pair and deframes 11-bit frames.
// Rev 1.0
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err_parity,
  output logic       err_frame,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_FRAME_BITS);

  logic                        clk_f;
  logic                        data_f;
  logic                        clk_q;
  logic                        fall;
  ps2_state_t                  state;
  ps2_state_t                  state_nxt;
  logic [BW-1:0]               bit_cnt;
  logic [PS2_PAYLOAD_BITS-1:0] shreg;
  logic [TW-1:0]               idle_cnt;
  logic                        timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_clk),
    .level (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst   (rst),
    .raw   (ps2_data),
    .level (data_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q <= 1'b1;
      fall  <= 1'b0;
    end else begin
      clk_q <= clk_f;
      fall  <= clk_q & ~clk_f;
    end
  end

  assign timeout = (idle_cnt == TW'(TIMEOUT_CYCLES));
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A clock fall always wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fall && !data_f) state_nxt = RECV;
      RECV: begin
        if (fall) begin
          if (bit_cnt == BW'(PS2_PAYLOAD_BITS - 1)) state_nxt = STOP;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      STOP: if (fall || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      idle_cnt   <= '0;
      data       <= 8'h00;
      valid      <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (fall || state == IDLE) idle_cnt <= '0;
      else if (!timeout)         idle_cnt <= idle_cnt + 1'b1;

      case (state)
        IDLE: if (fall && !data_f) bit_cnt <= '0;
        RECV: begin
          if (fall) begin
            shreg   <= {data_f, shreg[PS2_PAYLOAD_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (fall) begin
            data       <= shreg[7:0];
            err_parity <= (shreg[8] != odd_parity(shreg[7:0]));
            err_frame  <= ~data_f;
            valid      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx.sv
`default_nettype none
`timescale 1ns/1ps
// tb_ps2_rx -- keyboard-model bench for ps2_rx with an expected-byte scoreboard.
// Rev 1.0
module tb_ps2_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int HALF           = 40;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       err_parity;
  logic       err_frame;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   tests       = 0;
  int   fails       = 0;
  int   valid_count = 0;
  int   cyc         = 0;
  int   stop_cyc    = 0;
  logic prev_valid  = 1'b0;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .valid      (valid),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .busy       (busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every valid pops one expected byte and checks latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && prev_valid) begin
        tests++; fails++;
        $display("FAIL valid_double: valid high two cycles in a row, required single-cycle");
      end
      if (valid) begin
        valid_count++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: got data=%h pe=%b fe=%b, required no valid", data, err_parity, err_frame);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          tests++;
          if ({data, err_parity, err_frame} !== {e.d, e.pe, e.fe}) begin
            fails++;
            $display("FAIL frame_payload: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                     data, err_parity, err_frame, e.d, e.pe, e.fe);
          end
          tests++;
          if (cyc != stop_cyc + FILTER_LEN + 5) begin
            fails++;
            $display("FAIL valid_latency: got %0d cycles, required %0d", cyc - stop_cyc - 1, FILTER_LEN + 4);
          end
        end
      end
    end
    prev_valid = valid;
  end

  task automatic expect_byte(input logic [7:0] b, input logic pe, input logic fe);
    exp_t e;
    e.d = b; e.pe = pe; e.fe = fe;
    exp_q.push_back(e);
  endtask

  // Keyboard model: sends the first 'bits' bits of a frame, optional clock glitch in one bit.
  task automatic send_frame(input logic [7:0] b, input logic par_inv, input logic stop_val,
                            input int glitch_bit, input int bits);
    logic [10:0] fr;
    fr = {stop_val, (~^b) ^ par_inv, b, 1'b0};
    for (int i = 0; i < bits; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      if (i == glitch_bit) begin
        repeat (10) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 13) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (i == 10) stop_cyc = cyc;
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({data, valid, err_parity, err_frame, busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_hold: got data=%h v=%b pe=%b fe=%b busy=%b, required all 0",
               data, valid, err_parity, err_frame, busy);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    tests++;
    if ({data, valid, err_parity, err_frame, busy} !== 12'h000) begin
      fails++;
      $display("FAIL reset_release: got data=%h v=%b pe=%b fe=%b busy=%b, required all 0",
               data, valid, err_parity, err_frame, busy);
    end
  endtask

  task automatic test_single();
    expect_byte(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL single_pending: got %0d outstanding, required 0", exp_q.size());
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL single_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    expect_byte(8'h00, 1'b0, 1'b0);
    expect_byte(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b1, -1, 11);
    send_frame(8'hFF, 1'b0, 1'b1, -1, 11);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL b2b_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_errors();
    expect_byte(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b1, -1, 11);
    expect_byte(8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, -1, 11);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL errors_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_glitch_idle();
    int vc;
    logic seen_busy;
    vc = valid_count;
    seen_busy = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    tests++;
    if (seen_busy !== 1'b0) begin
      fails++; $display("FAIL glitch_idle_busy: got busy=1, required 0");
    end
    tests++;
    if (valid_count != vc) begin
      fails++; $display("FAIL glitch_idle_valid: got %0d pulses, required 0", valid_count - vc);
    end
  endtask

  task automatic test_glitch_frame();
    int vc;
    vc = valid_count;
    expect_byte(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 4, 11);
    tests++;
    if (valid_count != vc + 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL glitch_frame: got %0d pulses %0d outstanding, required 1 pulse 0 outstanding",
               valid_count - vc, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int vc;
    vc = valid_count;
    send_frame(8'h76, 1'b0, 1'b1, -1, 5);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL timeout_busy_mid: got %b, required 1", busy);
    end
    repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL timeout_busy_after: got %b, required 0", busy);
    end
    tests++;
    if (valid_count != vc) begin
      fails++; $display("FAIL timeout_valid: got %0d pulses, required 0", valid_count - vc);
    end
    expect_byte(8'h76, 1'b0, 1'b0);
    send_frame(8'h76, 1'b0, 1'b1, -1, 11);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL timeout_recover: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    int vc;
    vc = valid_count;
    fork
      send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
      begin
        repeat (5 * (2 * HALF + 1) + HALF + 10) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        tests++;
        if ({data, valid, err_parity, err_frame, busy} !== 12'h000) begin
          fails++;
          $display("FAIL reset_async: got data=%h v=%b pe=%b fe=%b busy=%b, required all 0",
                   data, valid, err_parity, err_frame, busy);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
      end
    join
    repeat (TIMEOUT_CYCLES + 50) @(negedge clk);
    tests++;
    if (valid_count != vc || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_remainder: got %0d pulses busy=%b, required 0 pulses busy=0", valid_count - vc, busy);
    end
    expect_byte(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, -1, 11);
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL reset_recover: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_glitch_idle();
    test_glitch_frame();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded its time budget");
    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
